// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-requester arbiter/sequencer for the single-port RAM
// Define SP_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sp_ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  win;
    logic                  grant;
    logic                  sel_we;
    logic                  any_req;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

`ifdef SP_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        grant = ~req0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end
    end
`else
    always_comb begin
        grant = ~req0;
    end
`endif

    assign any_req = req0 | req1;
    assign sel_we  = grant ? we1 : we0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = sel_we ? WR : RD_ADDR;
            WR:      state_nx = DONE;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win        <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef SP_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                win        <= grant;
                lat_addr   <= grant ? addr1 : addr0;
                lat_wdata  <= grant ? wdata1 : wdata0;
`ifdef SP_ARB_ROUND_ROBIN_EN
                last_grant <= grant;
`endif
            end
            // RAM output register was loaded at the end of RD_ADDR
            if (state == RD_DATA) begin
                if (win) begin
                    rdata1 <= ram_data;
                end else begin
                    rdata0 <= ram_data;
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign ram_cs      = (state == WR) || (state == RD_ADDR) || (state == RD_DATA);
    assign ram_we      = (state == WR);
    assign ram_oe      = (state == RD_ADDR) || (state == RD_DATA);
    assign ram_address = lat_addr;
    assign ack0        = (state == DONE) && !win;
    assign ack1        = (state == DONE) && win;
    assign ram_data    = (state == WR) ? lat_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - scoreboard bench for sp_ram_arbiter with a behavioural single-port RAM
module tb_sp_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata0, rdata1, ram_address;
    logic       ram_cs, ram_we, ram_oe;
    wire  [7:0] ram_data;

    logic [7:0] mem [256];
    logic [7:0] ram_q;

    typedef struct {
        int         port;
        bit         is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   failures = 0;
    int   conflicts = 0;
    int   idle_drive = 0;
    int   ack1_cnt = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_address(ram_address),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_data(ram_data)
    );

    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 8'hzz;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_address] <= ram_data;
        if (ram_cs && ram_oe && !ram_we) ram_q <= mem[ram_address];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we && ram_oe) conflicts <= conflicts + 1;
        if (!ram_cs && (ram_we || ram_oe)) idle_drive <= idle_drive + 1;
    end

    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            if (ack1) ack1_cnt++;
            chk_eq("single_ack", {31'b0, ack0 & ack1}, 32'd0);
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk_eq("ack_port", {31'b0, ack1}, e_mon.port);
                if (e_mon.is_rd)
                    chk_eq("rdata", e_mon.port ? rdata1 : rdata0, {24'b0, e_mon.data});
            end
        end
    end

    task automatic push_exp(input int port, input bit is_rd, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.is_rd = is_rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic run_txn(input int port, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] expd, input int lat);
        int n;
        bit got;
        @(negedge clk);
        if (port == 0) begin
            req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        push_exp(port, !we, expd);
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (port == 0 ? ack0 : ack1) got = 1;
        end
        chk_eq("latency", n, lat);
        if (port == 0) req0 = 0; else req1 = 0;
    endtask

    initial begin
        int cnt0, cnt1, cyc, a1;
        rst_n = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_ack", {ack1, ack0}, 0);
        chk_eq("rst_pins", {ram_cs, ram_we, ram_oe}, 0);
        chk_eq("rst_rdata", {rdata1, rdata0}, 0);
        chk_eq("rst_addr", ram_address, 0);

        // Write timing: WR after E0, ack after E1, IDLE after E2
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
        push_exp(0, 0, 8'h00);
        @(posedge clk); #1;
        chk_eq("wr_pins", {ram_cs, ram_we, ram_oe}, 3'b110);
        chk_eq("wr_data", ram_data, 8'hA5);
        chk_eq("wr_addr", ram_address, 8'h10);
        @(posedge clk); #1;
        chk_eq("wr_ack0", ack0, 1);
        chk_eq("wr_ack1", ack1, 0);
        chk_eq("done_pins", {ram_cs, ram_we, ram_oe}, 0);
        @(negedge clk);
        req0 = 0;
        @(posedge clk); #1;
        chk_eq("idle_busy", busy, 0);

        run_txn(0, 0, 8'h10, 8'h00, 8'hA5, 3);
        run_txn(1, 1, 8'h20, 8'h3C, 8'h00, 2);
        run_txn(0, 1, 8'h05, 8'h11, 8'h00, 2);

        // Reset so the arbitration history is known before the tie test
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;

        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 0; addr1 = 8'h20;
        push_exp(0, 1, 8'hA5);
        push_exp(1, 1, 8'h3C);
        cyc = 0;
        while ((req0 || req1) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (ack0) req0 = 0;
            if (ack1) req1 = 0;
        end
        chk_eq("tie_done", cyc < 30, 1);
        chk_eq("tie_rdata0", rdata0, 8'hA5);
        chk_eq("tie_rdata1", rdata1, 8'h3C);

        // Continuous requests: port 0 writes, port 1 reads back the same addresses
`ifdef SP_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            push_exp(0, 0, 8'h00);
            push_exp(1, 1, 8'h50 + i[7:0]);
        end
`else
        for (int i = 0; i < 4; i++) push_exp(0, 0, 8'h00);
        for (int i = 0; i < 4; i++) push_exp(1, 1, 8'h50 + i[7:0]);
`endif
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h50;
        req1 = 1; we1 = 0; addr1 = 8'h40;
        cnt0 = 0; cnt1 = 0; cyc = 0;
        while ((cnt0 < 4 || cnt1 < 4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ack0) begin
                cnt0++;
                if (cnt0 < 4) begin
                    addr0 = 8'h40 + cnt0[7:0]; wdata0 = 8'h50 + cnt0[7:0];
                end else req0 = 0;
            end
            if (ack1) begin
                cnt1++;
                if (cnt1 < 4) addr1 = 8'h40 + cnt1[7:0];
                else req1 = 0;
            end
        end
        chk_eq("stream_cnt0", cnt0, 4);
        chk_eq("stream_cnt1", cnt1, 4);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 8'hFF;
        @(posedge clk); #1;
        chk_eq("abort_in_wr", ram_we, 1);
        #2 rst_n = 0;
        #1;
        chk_eq("abort_pins", {ram_cs, ram_we, ram_oe}, 0);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_ack", {ack1, ack0}, 0);
        chk_eq("abort_rdata", {rdata1, rdata0}, 0);
        chk_eq("abort_addr", ram_address, 0);
        req0 = 0;
        @(negedge clk);
        rst_n = 1;
        run_txn(0, 0, 8'h05, 8'h00, 8'h11, 3);

        // Request dropped after the latch edge still completes once
        a1 = ack1_cnt;
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 8'h60; wdata1 = 8'h77;
        push_exp(1, 0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        req1 = 0; addr1 = 8'h00; wdata1 = 8'h00;
        repeat (6) @(negedge clk);
        chk_eq("drop_ack_once", ack1_cnt - a1, 1);
        run_txn(1, 0, 8'h60, 8'h00, 8'h77, 3);

        repeat (2) @(negedge clk);
        chk_eq("bus_conflict", conflicts, 0);
        chk_eq("idle_drive", idle_drive, 0);
        chk_eq("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
